// File: rtl/lspc_raster_timing_if.sv
// LSPC raster timing bus: pixel-enable strobe in, counters and decoded video
// timing out.
// Signals: PCK_EN (pixel-clock enable), PAL (start-line select, only with
// LSPC_PAL_MODE_EN), PIXELC/RASTERC counters, RASTER8, HSYNC, VSYNC,
// H_BLANK, V_BLANK, LINE_START, FRAME_START.
// Modports: master drives the enables, slave is the timing generator.
interface lspc_raster_timing_if;
  logic       PCK_EN;
`ifdef LSPC_PAL_MODE_EN
  logic       PAL;
`endif
  logic [8:0] PIXELC;
  logic [8:0] RASTERC;
  logic       RASTER8;
  logic       HSYNC;
  logic       VSYNC;
  logic       H_BLANK;
  logic       V_BLANK;
  logic       LINE_START;
  logic       FRAME_START;

  modport master (
`ifdef LSPC_PAL_MODE_EN
    output PAL,
`endif
    output PCK_EN,
    input  PIXELC, RASTERC, RASTER8, HSYNC, VSYNC,
    input  H_BLANK, V_BLANK, LINE_START, FRAME_START
  );

  modport slave (
`ifdef LSPC_PAL_MODE_EN
    input  PAL,
`endif
    input  PCK_EN,
    output PIXELC, RASTERC, RASTER8, HSYNC, VSYNC,
    output H_BLANK, V_BLANK, LINE_START, FRAME_START
  );
endinterface

// File: rtl/lspc_raster_timing.sv
// LSPC video timing generator. A pixel counter and a raster line counter
// advance on PCK_EN; sync, blanking, RASTER8 and line/frame strobes are
// registered decodes of the next counter values, so they move on the same
// edge as the counters.
// Ports: CLK (master clock), RESET (synchronous, active high),
//        bus (lspc_raster_timing_if.slave: PCK_EN/PAL in, timing out).
// Optional feature macro: LSPC_PAL_MODE_EN adds the PAL start-line select
// (312-line frame starting at 0x0C8, VSYNC on lines 0x0C8..0x0CF).
module lspc_raster_timing #(
  parameter int unsigned H_TOTAL    = 384,
  parameter int unsigned HSYNC_LEN  = 28,
  parameter int unsigned HVIS_START = 30,
  parameter int unsigned HVIS_END   = 350
) (
  input logic                  CLK,
  input logic                  RESET,
  lspc_raster_timing_if.slave  bus
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] PIX_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HSYNC_END     = CNT_W'(HSYNC_LEN);
  localparam logic [CNT_W-1:0] HVIS_FIRST    = CNT_W'(HVIS_START);
  localparam logic [CNT_W-1:0] HVIS_LIMIT    = CNT_W'(HVIS_END);
  localparam logic [CNT_W-1:0] V_START_NTSC  = 9'h0F8;
  localparam logic [CNT_W-1:0] V_LAST        = 9'h1FF;
  localparam logic [CNT_W-1:0] VSYNC_END     = 9'h100;
  localparam logic [CNT_W-1:0] VVIS_START    = 9'h110;
  localparam logic [CNT_W-1:0] VVIS_END      = 9'h1F0;
`ifdef LSPC_PAL_MODE_EN
  localparam logic [CNT_W-1:0] V_START_PAL   = 9'h0C8;
  localparam logic [CNT_W-1:0] VSYNC_END_PAL = 9'h0D0;
`endif

  logic [CNT_W-1:0] pixel_q, raster_q;
  logic [CNT_W-1:0] pixel_n_c, raster_n_c;
  logic [CNT_W-1:0] start_line_c, vsync_end_c;
  logic             line_wrap_c, frame_wrap_c;
  logic             hsync_q, vsync_q, h_blank_q, v_blank_q, raster8_q;
  logic             line_start_q, frame_start_q;

  // Start line and VSYNC length; PAL only matters at reload/reset, and the
  // latched frame mode keeps VSYNC consistent for the whole frame.
`ifdef LSPC_PAL_MODE_EN
  logic pal_q, pal_n_c;
  always_comb begin
    start_line_c = bus.PAL ? V_START_PAL : V_START_NTSC;
    pal_n_c      = frame_wrap_c ? bus.PAL : pal_q;
    vsync_end_c  = pal_n_c ? VSYNC_END_PAL : VSYNC_END;
  end
`else
  always_comb begin
    start_line_c = V_START_NTSC;
    vsync_end_c  = VSYNC_END;
  end
`endif

  // Next counter values. Raster always counts up to 0x1FF before reloading,
  // so an out-of-range value left by a mode change self-corrects.
  always_comb begin
    pixel_n_c    = pixel_q;
    raster_n_c   = raster_q;
    line_wrap_c  = 1'b0;
    frame_wrap_c = 1'b0;
    if (bus.PCK_EN) begin
      if (pixel_q == PIX_LAST) begin
        pixel_n_c   = '0;
        line_wrap_c = 1'b1;
        if (raster_q == V_LAST) begin
          raster_n_c   = start_line_c;
          frame_wrap_c = 1'b1;
        end else begin
          raster_n_c = raster_q + 9'd1;
        end
      end else begin
        pixel_n_c = pixel_q + 9'd1;
      end
    end
  end

  // Counters and decodes of the next values; reset values are the decodes
  // of PIXELC=0 / start line.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pixel_q       <= '0;
      raster_q      <= start_line_c;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      h_blank_q     <= 1'b1;
      v_blank_q     <= 1'b1;
      raster8_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef LSPC_PAL_MODE_EN
      pal_q         <= bus.PAL;
`endif
    end else begin
      pixel_q       <= pixel_n_c;
      raster_q      <= raster_n_c;
      hsync_q       <= (pixel_n_c < HSYNC_END);
      vsync_q       <= (raster_n_c < vsync_end_c);
      h_blank_q     <= (pixel_n_c < HVIS_FIRST) || (pixel_n_c >= HVIS_LIMIT);
      v_blank_q     <= (raster_n_c < VVIS_START) || (raster_n_c >= VVIS_END);
      raster8_q     <= raster_n_c[8];
      line_start_q  <= line_wrap_c;
      frame_start_q <= frame_wrap_c;
`ifdef LSPC_PAL_MODE_EN
      pal_q         <= pal_n_c;
`endif
    end
  end

  assign bus.PIXELC      = pixel_q;
  assign bus.RASTERC     = raster_q;
  assign bus.RASTER8     = raster8_q;
  assign bus.HSYNC       = hsync_q;
  assign bus.VSYNC       = vsync_q;
  assign bus.H_BLANK     = h_blank_q;
  assign bus.V_BLANK     = v_blank_q;
  assign bus.LINE_START  = line_start_q;
  assign bus.FRAME_START = frame_start_q;

endmodule

// File: tb/tb_lspc_raster_timing.sv
// Directed bench for lspc_raster_timing. Instance a uses the real line
// length; instance b uses an 8-pixel line so whole frames run quickly.
// Build with LSPC_PAL_MODE_EN to add the PAL scenario.
module tb_lspc_raster_timing;
  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  lspc_raster_timing_if a ();
  lspc_raster_timing_if b ();

  lspc_raster_timing u_a (.CLK(CLK), .RESET(RESET), .bus(a.slave));
  lspc_raster_timing #(.H_TOTAL(8), .HSYNC_LEN(2), .HVIS_START(3), .HVIS_END(6))
    u_b (.CLK(CLK), .RESET(RESET), .bus(b.slave));

  always #5 CLK = ~CLK;

  // Drive enables away from the edge, then sample 1 time unit after it.
  task automatic tick(input logic ea, input logic eb);
    @(negedge CLK);
    a.PCK_EN = ea;
    b.PCK_EN = eb;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    RESET = 1'b0;
    checks++; if (a.PIXELC !== 9'd0) begin errors++; $display("FAIL reset_pixelc got %h exp 000", a.PIXELC); end
    checks++; if (a.RASTERC !== 9'h0F8) begin errors++; $display("FAIL reset_rasterc got %h exp 0f8", a.RASTERC); end
    checks++; if (a.RASTER8 !== 1'b0) begin errors++; $display("FAIL reset_raster8 got %b exp 0", a.RASTER8); end
    checks++; if (a.HSYNC !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", a.HSYNC); end
    checks++; if (a.VSYNC !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", a.VSYNC); end
    checks++; if (a.H_BLANK !== 1'b1 || a.V_BLANK !== 1'b1) begin errors++; $display("FAIL reset_blank got %b%b exp 11", a.H_BLANK, a.V_BLANK); end
    checks++; if (a.LINE_START !== 1'b0 || a.FRAME_START !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", a.LINE_START, a.FRAME_START); end
    checks++; if (b.PIXELC !== 9'd0 || b.RASTERC !== 9'h0F8) begin errors++; $display("FAIL reset_b got %h/%h exp 000/0f8", b.PIXELC, b.RASTERC); end
  endtask

  // One line on instance a with PCK_EN every 4th CLK.
  task automatic test_line;
    int ls_count = 0;
    for (int n = 1; n <= 384; n++) begin
      logic [8:0] exp_px;
      logic       exp_hs, exp_hb;
      exp_px = 9'(n % 384);
      exp_hs = (exp_px < 9'd28);
      exp_hb = (exp_px < 9'd30) || (exp_px >= 9'd350);
      tick(1'b1, 1'b0);
      if (a.LINE_START === 1'b1) ls_count++;
      checks++; if (a.PIXELC !== exp_px) begin errors++; $display("FAIL line_pixelc n=%0d got %0d exp %0d", n, a.PIXELC, exp_px); end
      checks++; if (a.HSYNC !== exp_hs) begin errors++; $display("FAIL line_hsync n=%0d got %b exp %b", n, a.HSYNC, exp_hs); end
      checks++; if (a.H_BLANK !== exp_hb) begin errors++; $display("FAIL line_hblank n=%0d got %b exp %b", n, a.H_BLANK, exp_hb); end
      if (n == 384) begin
        checks++; if (a.LINE_START !== 1'b1) begin errors++; $display("FAIL line_start_pulse got %b exp 1", a.LINE_START); end
        checks++; if (a.FRAME_START !== 1'b0) begin errors++; $display("FAIL line_frame_start got %b exp 0", a.FRAME_START); end
        checks++; if (a.RASTERC !== 9'h0F9) begin errors++; $display("FAIL line_rasterc got %h exp 0f9", a.RASTERC); end
      end
      for (int k = 0; k < 3; k++) begin
        tick(1'b0, 1'b0);
        if (a.LINE_START === 1'b1) ls_count++;
      end
      checks++; if (a.PIXELC !== exp_px || a.HSYNC !== exp_hs) begin errors++; $display("FAIL line_hold n=%0d got %0d/%b exp %0d/%b", n, a.PIXELC, a.HSYNC, exp_px, exp_hs); end
    end
    checks++; if (ls_count != 1) begin errors++; $display("FAIL line_start_count got %0d exp 1", ls_count); end
  endtask

  // Continuous PCK_EN to line 0x150 pixel 200, then reset and freeze.
  task automatic test_mid_reset;
    for (int n = 0; n < 87 * 384 + 200; n++) tick(1'b1, 1'b0);
    checks++; if (a.PIXELC !== 9'd200 || a.RASTERC !== 9'h150) begin errors++; $display("FAIL mid_position got %0d/%h exp 200/150", a.PIXELC, a.RASTERC); end
    checks++; if ({a.RASTER8, a.VSYNC, a.V_BLANK, a.H_BLANK, a.HSYNC} !== 5'b10000) begin errors++; $display("FAIL mid_decodes got %b exp 10000", {a.RASTER8, a.VSYNC, a.V_BLANK, a.H_BLANK, a.HSYNC}); end
    RESET = 1'b1;
    tick(1'b1, 1'b0);
    RESET = 1'b0;
    checks++; if (a.PIXELC !== 9'd0 || a.RASTERC !== 9'h0F8) begin errors++; $display("FAIL mid_reset_counters got %0d/%h exp 0/0f8", a.PIXELC, a.RASTERC); end
    checks++; if (a.LINE_START !== 1'b0 || a.FRAME_START !== 1'b0) begin errors++; $display("FAIL mid_reset_strobes got %b%b exp 00", a.LINE_START, a.FRAME_START); end
    for (int n = 0; n < 50; n++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (a.PIXELC !== 9'd0 || a.RASTERC !== 9'h0F8 ||
          {a.HSYNC, a.VSYNC, a.H_BLANK, a.V_BLANK, a.RASTER8, a.LINE_START, a.FRAME_START} !== 7'b1111000) begin
        errors++;
        $display("FAIL freeze n=%0d got %0d/%h/%b exp 0/0f8/1111000", n, a.PIXELC, a.RASTERC,
                 {a.HSYNC, a.VSYNC, a.H_BLANK, a.V_BLANK, a.RASTER8, a.LINE_START, a.FRAME_START});
      end
    end
  endtask

  // One full NTSC frame on instance b (264 lines x 8 pixels).
  task automatic test_frame;
    int ls = 0, fs = 0, vs_lines = 0, vis_lines = 0, r8_rise = 0, r8_fall = 0;
    logic       prev_r8 = 1'b0;
    logic [8:0] prev_r  = 9'h0F8;
    for (int n = 0; n < 264 * 8; n++) begin
      tick(1'b0, 1'b1);
      if (b.LINE_START === 1'b1) begin
        ls++;
        if (b.VSYNC === 1'b1) vs_lines++;
        if (b.V_BLANK === 1'b0) vis_lines++;
      end
      if (b.FRAME_START === 1'b1) begin
        fs++;
        checks++;
        if (b.LINE_START !== 1'b1 || prev_r !== 9'h1FF || b.RASTERC !== 9'h0F8) begin
          errors++; $display("FAIL frame_reload got ls=%b %h->%h exp ls=1 1ff->0f8", b.LINE_START, prev_r, b.RASTERC);
        end
      end
      if (b.RASTER8 === 1'b1 && prev_r8 === 1'b0) begin
        r8_rise++;
        checks++;
        if (b.RASTERC !== 9'h100 || b.PIXELC !== 9'd0) begin errors++; $display("FAIL raster8_rise_pos got %h/%0d exp 100/0", b.RASTERC, b.PIXELC); end
      end
      if (b.RASTER8 === 1'b0 && prev_r8 === 1'b1) r8_fall++;
      prev_r8 = b.RASTER8;
      prev_r  = b.RASTERC;
    end
    checks++; if (ls != 264) begin errors++; $display("FAIL frame_line_starts got %0d exp 264", ls); end
    checks++; if (fs != 1) begin errors++; $display("FAIL frame_starts got %0d exp 1", fs); end
    checks++; if (vs_lines != 8) begin errors++; $display("FAIL frame_vsync_lines got %0d exp 8", vs_lines); end
    checks++; if (vis_lines != 224) begin errors++; $display("FAIL frame_visible_lines got %0d exp 224", vis_lines); end
    checks++; if (r8_rise != 1 || r8_fall != 1) begin errors++; $display("FAIL frame_raster8_edges got %0d/%0d exp 1/1", r8_rise, r8_fall); end
    checks++; if (b.PIXELC !== 9'd0 || b.RASTERC !== 9'h0F8 || b.RASTER8 !== 1'b0) begin errors++; $display("FAIL frame_end got %0d/%h/%b exp 0/0f8/0", b.PIXELC, b.RASTERC, b.RASTER8); end
  endtask

`ifdef LSPC_PAL_MODE_EN
  // PAL frame on instance b, then a mid-frame switch back to NTSC.
  task automatic test_pal;
    int fs = 0, vs_lines = 0;
    b.PAL = 1'b1;
    RESET = 1'b1;
    tick(1'b0, 1'b1);
    RESET = 1'b0;
    checks++; if (b.RASTERC !== 9'h0C8 || b.VSYNC !== 1'b1) begin errors++; $display("FAIL pal_reset got %h/%b exp 0c8/1", b.RASTERC, b.VSYNC); end
    for (int n = 0; n < 312 * 8; n++) begin
      tick(1'b0, 1'b1);
      if (b.FRAME_START === 1'b1) fs++;
      if (b.LINE_START === 1'b1 && b.VSYNC === 1'b1) vs_lines++;
    end
    checks++; if (fs != 1 || b.RASTERC !== 9'h0C8) begin errors++; $display("FAIL pal_frame got fs=%0d r=%h exp fs=1 r=0c8", fs, b.RASTERC); end
    checks++; if (vs_lines != 8) begin errors++; $display("FAIL pal_vsync_lines got %0d exp 8", vs_lines); end
    for (int n = 0; n < (9'h180 - 9'h0C8) * 8; n++) tick(1'b0, 1'b1);
    checks++; if (b.RASTERC !== 9'h180) begin errors++; $display("FAIL pal_line180 got %h exp 180", b.RASTERC); end
    b.PAL = 1'b0;
    for (int n = 0; n < (9'h1FF - 9'h180) * 8; n++) tick(1'b0, 1'b1);
    checks++; if (b.RASTERC !== 9'h1FF) begin errors++; $display("FAIL pal_no_early_reload got %h exp 1ff", b.RASTERC); end
    for (int n = 0; n < 8; n++) tick(1'b0, 1'b1);
    checks++; if (b.RASTERC !== 9'h0F8 || b.FRAME_START !== 1'b1) begin errors++; $display("FAIL pal_switch_reload got %h/%b exp 0f8/1", b.RASTERC, b.FRAME_START); end
  endtask
`endif

  initial begin
    RESET    = 1'b1;
    a.PCK_EN = 1'b0;
    b.PCK_EN = 1'b0;
`ifdef LSPC_PAL_MODE_EN
    a.PAL    = 1'b0;
    b.PAL    = 1'b0;
`endif
    test_reset();
    test_line();
    test_mid_reset();
    test_frame();
`ifdef LSPC_PAL_MODE_EN
    test_pal();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
